// File: rtl/ysyx_23060077_ifu_fetchq_pkg.sv
// ============================================================================
// ysyx_23060077_ifu_fetchq_pkg : shared types and defaults for the fetch queue
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_23060077_ifu_fetchq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h2000_0000;
  localparam int          INST_WIDTH       = 32;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060077_ifu_fetchq_sync_fifo.sv
// ============================================================================
// ysyx_23060077_sync_fifo : synchronous FIFO, flush/push/pop, combinational head
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_23060077_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_w;
  logic             pop_w;

  assign push_w  = push_i && (count_q != CW'(DEPTH));
  assign pop_w   = pop_i && (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_w)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_w && !pop_w)      count_q <= count_q + CW'(1);
      else if (pop_w && !push_w) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_w && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060077_ifu_fetchq.sv
// ============================================================================
// ysyx_23060077_ifu_fetchq : burst-prefetching IFU feeding an instruction queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_23060077_ifu_fetchq
  import ysyx_23060077_ifu_fetchq_pkg::*;
#(
  parameter int                    DATA_WIDTH = INST_WIDTH,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    BURST_LEN  = 4,
  parameter int                    FQ_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  ifu_r_valid_o,
  output logic [ADDR_WIDTH-1:0] ifu_r_addr_o,
  output logic [7:0]            ifu_r_len_o,
  input  logic                  ifu_r_ready_i,
  input  logic                  ifu_r_dvalid_i,
  input  logic [DATA_WIDTH-1:0] ifu_r_data_i,
  input  logic                  ifu_r_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH-1:0] out_pc_o,
  output logic [DATA_WIDTH-1:0] out_inst_o
);

  localparam int                  CNT_W    = $clog2(FQ_DEPTH) + 1;
  localparam int                  ENT_W    = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0]    MAX_FILL = CNT_W'(FQ_DEPTH - BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(4);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] beat_pc_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  pend_q;

  logic [ADDR_WIDTH-1:0] redir_tgt_w;
  logic [ENT_W-1:0]      head_w;
  logic [CNT_W-1:0]      count_w;
  logic                  empty_w;
  logic                  push_w;
  logic                  pop_w;
  logic                  room_w;
  logic                  beat_end_w;

  assign redir_tgt_w = redirect_pc & ~ADDR_WIDTH'(3);
  assign beat_end_w  = ifu_r_dvalid_i && ifu_r_last_i;
  assign push_w      = (state_q == ST_RESP) && ifu_r_dvalid_i && !redirect_valid;
  assign pop_w       = out_ready_i && !empty_w && !redirect_valid;
  // A whole burst of slots is reserved before the request goes out.
  assign room_w      = (count_w <= MAX_FILL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      beat_pc_q  <= RESET_PC;
      req_addr_q <= RESET_PC;
      pend_q     <= 1'b0;
    end else begin
      if (redirect_valid) fetch_pc_q <= redir_tgt_w;
      case (state_q)
        ST_IDLE: begin
          if (!redirect_valid && room_w) begin
            state_q    <= ST_REQ;
            req_addr_q <= fetch_pc_q;
          end
        end
        ST_REQ: begin
          // The request cannot be withdrawn, so a redirect here only marks the burst as dead.
          if (ifu_r_ready_i) begin
            state_q   <= (pend_q || redirect_valid) ? ST_DRAIN : ST_RESP;
            beat_pc_q <= req_addr_q;
            pend_q    <= 1'b0;
          end else if (redirect_valid) begin
            pend_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (push_w) begin
            beat_pc_q  <= beat_pc_q + STEP;
            fetch_pc_q <= fetch_pc_q + STEP;
          end
          if (beat_end_w)          state_q <= ST_IDLE;
          else if (redirect_valid) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (beat_end_w) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ysyx_23060077_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (push_w),
    .data_i  ({beat_pc_q, ifu_r_data_i}),
    .pop_i   (pop_w),
    .data_o  (head_w),
    .count_o (count_w),
    .empty_o (empty_w)
  );

  assign ifu_r_valid_o = (state_q == ST_REQ);
  assign ifu_r_addr_o  = req_addr_q;
  assign ifu_r_len_o   = 8'(BURST_LEN - 1);
  assign out_valid_o   = !empty_w;
  assign out_pc_o      = empty_w ? '0 : head_w[ENT_W-1:DATA_WIDTH];
  assign out_inst_o    = empty_w ? '0 : head_w[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060077_ifu_fetchq.sv
// ============================================================================
// tb_ysyx_23060077_ifu_fetchq : directed + random bench with a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060077_ifu_fetchq;

  localparam int BL    = 4;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ifu_r_valid_o;
  logic [31:0] ifu_r_addr_o;
  logic [7:0]  ifu_r_len_o;
  logic        ifu_r_ready_i = 1'b0;
  logic        ifu_r_dvalid_i = 1'b0;
  logic [31:0] ifu_r_data_i = '0;
  logic        ifu_r_last_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;

  ysyx_23060077_ifu_fetchq #(
    .BURST_LEN (BL),
    .FQ_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifu_r_valid_o  (ifu_r_valid_o),
    .ifu_r_addr_o   (ifu_r_addr_o),
    .ifu_r_len_o    (ifu_r_len_o),
    .ifu_r_ready_i  (ifu_r_ready_i),
    .ifu_r_dvalid_i (ifu_r_dvalid_i),
    .ifu_r_data_i   (ifu_r_data_i),
    .ifu_r_last_i   (ifu_r_last_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_pc_o       (out_pc_o),
    .out_inst_o     (out_inst_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Behavioural model: expected queue contents plus the burst bookkeeping.
  ent_t        mq[$];
  logic [31:0] m_fetch, m_req_addr, m_beat;
  bit          m_req, m_burst, m_drop, m_pend;

  // Memory-side agent state.
  bit          sl_active;
  logic [31:0] sl_addr;
  int          sl_cnt, sl_len, short_next, n_req;
  logic [31:0] req_log[$];

  // Stimulus knobs (percentages) and one-shot overrides.
  int          k_rdy, k_dv, k_out, k_redir, k_junk;
  bit          k_short, f_redir, f_rdy_off;
  logic [31:0] f_target;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h13C0_5A93;
  endfunction

  function automatic bit pct(input int p);
    return ($urandom_range(0, 99) < p);
  endfunction

  function automatic logic [31:0] req_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 'x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic done_chk(input string nm, input bit ok);
    n_checks++;
    if (!ok) begin
      n_errs++;
      $display("FAIL %s: condition not reached within budget at %0t", nm, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fetch = 32'h2000_0000; m_req_addr = 32'h2000_0000; m_beat = 32'h2000_0000;
    m_req = 0; m_burst = 0; m_drop = 0; m_pend = 0;
  endtask

  task automatic compare_all();
    ent_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    chk("r_valid", ifu_r_valid_o, m_req);
    if (m_req) chk("r_addr", ifu_r_addr_o, m_req_addr);
    chk("r_len", ifu_r_len_o, 8'(BL - 1));
    chk("out_valid", out_valid_o, mq.size() != 0);
    chk("out_pc", out_pc_o, h.pc);
    chk("out_inst", out_inst_o, h.inst);
  endtask

  task automatic model_update();
    int          sz;
    logic [31:0] tgt;
    ent_t        e;
    sz  = mq.size();
    tgt = redirect_pc & 32'hFFFF_FFFC;
    if (redirect_valid) begin
      mq.delete();
      m_fetch = tgt;
    end else begin
      if (out_ready_i && sz > 0) void'(mq.pop_front());
      if (m_burst && !m_drop && ifu_r_dvalid_i) begin
        e.pc = m_beat; e.inst = ifu_r_data_i;
        mq.push_back(e);
        m_beat  = m_beat + 4;
        m_fetch = m_fetch + 4;
      end
    end
    if (m_req) begin
      if (ifu_r_ready_i) begin
        m_req = 0; m_burst = 1; m_drop = m_pend || redirect_valid; m_pend = 0; m_beat = m_req_addr;
      end else if (redirect_valid) begin
        m_pend = 1;
      end
    end else if (m_burst) begin
      if (ifu_r_dvalid_i && ifu_r_last_i) m_burst = 0;
      else if (redirect_valid) m_drop = 1;
    end else if (!redirect_valid && (DEPTH - sz) >= BL) begin
      m_req = 1; m_req_addr = m_fetch;
    end
  endtask

  task automatic drive();
    bit dv;
    ifu_r_ready_i = !f_rdy_off && pct(k_rdy);
    if (sl_active) begin
      dv = pct(k_dv);
      ifu_r_dvalid_i = dv;
      ifu_r_data_i   = inst_of(sl_addr + 32'(4 * sl_cnt));
      ifu_r_last_i   = dv && (sl_cnt + 1 == sl_len);
    end else begin
      ifu_r_dvalid_i = pct(k_junk);
      ifu_r_data_i   = $urandom;
      ifu_r_last_i   = 1'b0;
    end
    out_ready_i = pct(k_out);
    if (f_redir) begin
      redirect_valid = 1'b1; redirect_pc = f_target; f_redir = 0;
    end else begin
      redirect_valid = pct(k_redir);
      redirect_pc    = 32'h2000_0000 + ($urandom & 32'h0000_0FFF);
    end
  endtask

  task automatic slave_update();
    if (sl_active && ifu_r_dvalid_i) begin
      sl_cnt++;
      if (ifu_r_last_i) sl_active = 0;
    end
    if (ifu_r_valid_o && ifu_r_ready_i) begin
      sl_active = 1; sl_addr = ifu_r_addr_o; sl_cnt = 0;
      if (short_next != 0) sl_len = short_next;
      else if (k_short && $urandom_range(0, 7) == 0) sl_len = $urandom_range(1, BL);
      else sl_len = BL;
      short_next = 0;
      n_req++;
      req_log.push_back(ifu_r_addr_o);
    end
  endtask

  // One clock: inputs change at the falling edge, outputs are compared at the next one.
  task automatic cyc();
    drive();
    model_update();
    slave_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 0; ifu_r_ready_i = 0; ifu_r_dvalid_i = 0; ifu_r_last_i = 0; out_ready_i = 0;
    sl_active = 0; short_next = 0;
    repeat (2) @(negedge clk);
    chk("rst_r_valid", ifu_r_valid_o, 1'b0);
    chk("rst_r_addr", ifu_r_addr_o, 32'h2000_0000);
    chk("rst_r_len", ifu_r_len_o, 8'd3);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_pc", out_pc_o, 32'h0);
    chk("rst_out_inst", out_inst_o, 32'h0);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    n_req = 0; f_redir = 0; f_rdy_off = 0; k_short = 0; k_junk = 0; k_redir = 0;
    k_rdy = 100; k_dv = 100; k_out = 0;
    @(negedge clk);
    do_reset();

    // Fill with the consumer stalled: two bursts, then no further request.
    cyc();
    chk("first_req_valid", ifu_r_valid_o, 1'b1);
    chk("first_req_addr", ifu_r_addr_o, 32'h2000_0000);
    repeat (30) cyc();
    chk("stall_nreq", n_req, 2);
    chk("stall_req0", req_at(0), 32'h2000_0000);
    chk("stall_req1", req_at(1), 32'h2000_0010);
    chk("stall_no_req", ifu_r_valid_o, 1'b0);
    chk("stall_model_full", mq.size(), 8);
    chk("stall_head_pc", out_pc_o, 32'h2000_0000);
    chk("stall_head_inst", out_inst_o, inst_of(32'h2000_0000));
    k_out = 100;
    repeat (4) cyc();
    k_out = 0;
    chk("pop4_head_pc", out_pc_o, 32'h2000_0010);
    chk("pop4_nreq", n_req, 2);
    for (t = 0; t < 10 && n_req < 3; t++) cyc();
    done_chk("third_req", n_req >= 3);
    chk("third_req_addr", req_at(2), 32'h2000_0020);

    // Redirect after the second beat of a burst.
    for (t = 0; t < 20 && !(sl_active && sl_cnt == 2); t++) cyc();
    done_chk("beat2_reached", sl_active && sl_cnt == 2);
    f_redir = 1; f_target = 32'h2000_0100;
    cyc();
    chk("redir_flush_valid", out_valid_o, 1'b0);
    for (t = 0; t < 20 && n_req < 4; t++) cyc();
    done_chk("redir_req", n_req >= 4);
    chk("redir_req_addr", req_at(3), 32'h2000_0100);
    k_out = 100;
    for (t = 0; t < 20 && !out_valid_o; t++) cyc();
    chk("redir_first_pc", out_pc_o, 32'h2000_0100);

    // Redirect while the request is waiting for the arbiter.
    f_rdy_off = 1;
    for (t = 0; t < 20 && !m_req; t++) cyc();
    done_chk("req_wait", m_req);
    chk("req_old_addr", ifu_r_addr_o, 32'h2000_0110);
    f_redir = 1; f_target = 32'h2000_0203;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("req_held_valid", ifu_r_valid_o, 1'b1);
      chk("req_held_addr", ifu_r_addr_o, 32'h2000_0110);
    end
    f_rdy_off = 0;
    for (t = 0; t < 30 && n_req < 6; t++) cyc();
    done_chk("pend_req", n_req >= 6);
    chk("pend_req_addr", req_at(5), 32'h2000_0200);
    for (t = 0; t < 20 && !out_valid_o; t++) cyc();
    chk("pend_first_pc", out_pc_o, 32'h2000_0200);

    // Redirect together with a pop and an incoming beat, then a short burst.
    for (t = 0; t < 20 && !(mq.size() > 0 && sl_active && m_burst && !m_drop); t++) cyc();
    done_chk("coincide_reached", mq.size() > 0 && sl_active && m_burst && !m_drop);
    f_redir = 1; f_target = 32'h2000_0300; short_next = 2;
    cyc();
    chk("coincide_out_valid", out_valid_o, 1'b0);
    chk("coincide_model_empty", mq.size(), 0);
    for (t = 0; t < 40 && n_req < 8; t++) cyc();
    done_chk("short_reqs", n_req >= 8);
    chk("short_req_addr", req_at(6), 32'h2000_0300);
    chk("after_short_addr", req_at(7), 32'h2000_0308);

    // Randomised traffic, including a reset in the middle of activity.
    k_rdy = 60; k_dv = 70; k_out = 50; k_redir = 3; k_short = 1; k_junk = 5;
    repeat (1500) cyc();
    k_out = 10;
    repeat (500) cyc();
    k_out = 50;
    do_reset();
    repeat (1500) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

`default_nettype wire
